// File: rtl/virgule_sequencer.sv
// Virgule multi-cycle sequencer: fetch/decode/execute/memory/writeback control,
// memory-bus handshake, datapath write enables and edge-triggered interrupt entry.
package virgule_pkg;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_mret;
        logic has_rd;
    } instruction_t;

endpackage

module virgule_sequencer
    import virgule_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  instruction_t instr,
    input  logic         bus_ready,
    input  logic         irq,
    output logic         bus_valid,
    output logic         bus_write,
    output logic         is_fetch,
    output logic         is_decode,
    output logic         is_execute,
    output logic         is_load,
    output logic         is_store,
    output logic         is_writeback,
    output logic         instr_we,
    output logic         pc_we,
    output logic         rd_we,
    output logic         irq_taken,
    output logic         in_handler
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_LOAD,
        ST_STORE,
        ST_WRITEBACK
    } state_t;

    state_t r_state;
    logic   r_irq_q;
    logic   r_irq_pending;
    logic   r_in_handler;

    logic   w_fetch;
    logic   w_decode;
    logic   w_execute;
    logic   w_load;
    logic   w_store;
    logic   w_writeback;
    logic   w_irq_edge;
    logic   w_irq_take;
    logic   w_mret_retire;

    assign w_fetch     = (r_state == ST_FETCH);
    assign w_decode    = (r_state == ST_DECODE);
    assign w_execute   = (r_state == ST_EXECUTE);
    assign w_load      = (r_state == ST_LOAD);
    assign w_store     = (r_state == ST_STORE);
    assign w_writeback = (r_state == ST_WRITEBACK);

    // Take decision uses only registered interrupt state, so irq never reaches an output.
    assign w_irq_edge     = irq & ~r_irq_q;
    assign w_irq_take     = w_writeback & r_irq_pending & ~r_in_handler;
    assign w_mret_retire  = w_writeback & instr.is_mret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_irq_q       <= 1'b0;
            r_irq_pending <= 1'b0;
            r_in_handler  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FETCH:     if (bus_ready) r_state <= ST_DECODE;
                ST_DECODE:    r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (instr.is_load)       r_state <= ST_LOAD;
                    else if (instr.is_store) r_state <= ST_STORE;
                    else                     r_state <= ST_WRITEBACK;
                end
                ST_LOAD:      if (bus_ready) r_state <= ST_WRITEBACK;
                ST_STORE:     if (bus_ready) r_state <= ST_WRITEBACK;
                ST_WRITEBACK: r_state <= ST_FETCH;
                default:      r_state <= ST_FETCH;
            endcase

            r_irq_q <= irq;

            // A fresh edge wins over the clear caused by taking the previous one.
            if (w_irq_edge)      r_irq_pending <= 1'b1;
            else if (w_irq_take) r_irq_pending <= 1'b0;

            if (w_irq_take)         r_in_handler <= 1'b1;
            else if (w_mret_retire) r_in_handler <= 1'b0;
        end
    end

    always_comb begin
        is_fetch     = w_fetch;
        is_decode    = w_decode;
        is_execute   = w_execute;
        is_load      = w_load;
        is_store     = w_store;
        is_writeback = w_writeback;

        bus_valid    = (w_fetch | w_load | w_store) & ~reset;
        bus_write    = w_store & ~reset;
        instr_we     = w_fetch & bus_ready & ~reset;
        pc_we        = w_writeback & ~reset;
        rd_we        = w_writeback & instr.has_rd & ~reset;
        irq_taken    = w_irq_take & ~reset;
        in_handler   = r_in_handler;
    end

endmodule

// File: tb/tb_virgule_sequencer.sv
// Scoreboard bench for virgule_sequencer: per-cycle expected output vectors are queued
// by the driver and compared against the DUT on the falling edge.
module tb_virgule_sequencer;
    import virgule_pkg::*;

    localparam logic [5:0] SF = 6'b100000;
    localparam logic [5:0] SD = 6'b010000;
    localparam logic [5:0] SE = 6'b001000;
    localparam logic [5:0] SL = 6'b000100;
    localparam logic [5:0] SS = 6'b000010;
    localparam logic [5:0] SW = 6'b000001;

    localparam instruction_t I_ADD  = '{is_load: 1'b0, is_store: 1'b0, is_mret: 1'b0, has_rd: 1'b1};
    localparam instruction_t I_LW   = '{is_load: 1'b1, is_store: 1'b0, is_mret: 1'b0, has_rd: 1'b1};
    localparam instruction_t I_SW   = '{is_load: 1'b0, is_store: 1'b1, is_mret: 1'b0, has_rd: 1'b0};
    localparam instruction_t I_BEQ  = '{is_load: 1'b0, is_store: 1'b0, is_mret: 1'b0, has_rd: 1'b0};
    localparam instruction_t I_MRET = '{is_load: 1'b0, is_store: 1'b0, is_mret: 1'b1, has_rd: 1'b0};

    typedef struct {
        string       tag;
        logic [12:0] v;
    } sb_t;

    logic         clk;
    logic         reset;
    instruction_t instr;
    logic         bus_ready;
    logic         irq;
    logic         bus_valid, bus_write;
    logic         is_fetch, is_decode, is_execute, is_load, is_store, is_writeback;
    logic         instr_we, pc_we, rd_we, irq_taken, in_handler;

    logic [12:0]  w_obs;
    sb_t          sb[$];
    sb_t          r_ent;
    int unsigned  n_checks;
    int unsigned  n_fail;

    virgule_sequencer u_dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .bus_ready    (bus_ready),
        .irq          (irq),
        .bus_valid    (bus_valid),
        .bus_write    (bus_write),
        .is_fetch     (is_fetch),
        .is_decode    (is_decode),
        .is_execute   (is_execute),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_writeback (is_writeback),
        .instr_we     (instr_we),
        .pc_we        (pc_we),
        .rd_we        (rd_we),
        .irq_taken    (irq_taken),
        .in_handler   (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_obs = {is_fetch, is_decode, is_execute, is_load, is_store, is_writeback,
                    bus_valid, bus_write, instr_we, pc_we, rd_we, irq_taken, in_handler};

    task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (FDELSW bv bw iwe pwe rwe itk inh)", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [5:0] st, input logic bv, input logic bw,
                                       input logic iwe, input logic pwe, input logic rwe,
                                       input logic itk, input logic inh);
        return {st, bv, bw, iwe, pwe, rwe, itk, inh};
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            r_ent = sb.pop_front();
            check_val(r_ent.tag, w_obs, r_ent.v);
        end
    end

    task automatic cyc(input string tag, input logic rst, input instruction_t i,
                       input logic rdy, input logic q, input logic [12:0] e);
        sb_t ent;
        reset     = rst;
        instr     = i;
        bus_ready = rdy;
        irq       = q;
        ent.tag   = tag;
        ent.v     = e;
        sb.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    // One full instruction; in_handler is constant until the writeback edge.
    task automatic do_instr(input string nm, input instruction_t i,
                            input int unsigned fwaits, input int unsigned mwaits,
                            input logic irq_base, input logic irq_dec,
                            input logic inh, input logic itk);
        logic [5:0] mst;
        mst = i.is_load ? SL : SS;
        for (int unsigned k = 0; k < fwaits; k++)
            cyc({nm, "/Fwait"}, 1'b0, i, 1'b0, irq_base, mk(SF, 1, 0, 0, 0, 0, 0, inh));
        cyc({nm, "/F"}, 1'b0, i, 1'b1, irq_base, mk(SF, 1, 0, 1, 0, 0, 0, inh));
        cyc({nm, "/D"}, 1'b0, i, 1'b1, irq_dec,  mk(SD, 0, 0, 0, 0, 0, 0, inh));
        cyc({nm, "/E"}, 1'b0, i, 1'b1, irq_base, mk(SE, 0, 0, 0, 0, 0, 0, inh));
        if (i.is_load || i.is_store) begin
            for (int unsigned k = 0; k < mwaits; k++)
                cyc({nm, "/Mwait"}, 1'b0, i, 1'b0, irq_base, mk(mst, 1, i.is_store, 0, 0, 0, 0, inh));
            cyc({nm, "/M"}, 1'b0, i, 1'b1, irq_base, mk(mst, 1, i.is_store, 0, 0, 0, 0, inh));
        end
        cyc({nm, "/W"}, 1'b0, i, 1'b1, irq_base, mk(SW, 0, 0, 0, 1, i.has_rd, itk, inh));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        instr     = I_ADD;
        bus_ready = 1'b1;
        irq       = 1'b0;
        @(posedge clk);
        #1;

        cyc("rst0", 1'b1, I_ADD, 1'b1, 1'b0, mk(SF, 0, 0, 0, 0, 0, 0, 0));
        cyc("rst1", 1'b1, I_ADD, 1'b1, 1'b0, mk(SF, 0, 0, 0, 0, 0, 0, 0));

        do_instr("ADD",  I_ADD,  0, 0, 0, 0, 0, 0);
        do_instr("LW",   I_LW,   0, 3, 0, 0, 0, 0);
        do_instr("SW",   I_SW,   1, 0, 0, 0, 0, 0);
        do_instr("BEQ",  I_BEQ,  0, 0, 0, 0, 0, 0);

        // Pulse during DECODE: taken at this writeback, second pulse waits for MRET.
        do_instr("IRQ1", I_ADD,  0, 0, 0, 1, 0, 1);
        do_instr("IRQ2", I_ADD,  0, 0, 0, 1, 1, 0);
        do_instr("MRT1", I_MRET, 0, 0, 0, 0, 1, 0);
        do_instr("IRQ3", I_ADD,  0, 0, 0, 0, 0, 1);
        do_instr("MRT2", I_MRET, 0, 0, 0, 0, 1, 0);
        do_instr("POST", I_BEQ,  0, 0, 0, 0, 0, 0);

        // Enter handler, leave a pending edge, then reset in the middle of a stalled store.
        do_instr("IRQ4", I_ADD,  0, 0, 0, 1, 0, 1);
        cyc("RS/F", 1'b0, I_SW, 1'b1, 1'b0, mk(SF, 1, 0, 1, 0, 0, 0, 1));
        cyc("RS/D", 1'b0, I_SW, 1'b1, 1'b1, mk(SD, 0, 0, 0, 0, 0, 0, 1));
        cyc("RS/E", 1'b0, I_SW, 1'b1, 1'b0, mk(SE, 0, 0, 0, 0, 0, 0, 1));
        cyc("RS/S", 1'b0, I_SW, 1'b0, 1'b0, mk(SS, 1, 1, 0, 0, 0, 0, 1));
        cyc("RS/rst", 1'b1, I_SW, 1'b0, 1'b0, mk(SF, 0, 0, 0, 0, 0, 0, 0));
        cyc("RS/rst2", 1'b1, I_SW, 1'b1, 1'b0, mk(SF, 0, 0, 0, 0, 0, 0, 0));
        do_instr("RS/ADD", I_ADD, 0, 0, 0, 0, 0, 0);

        // Level held high across ten instructions: only the first edge is taken.
        do_instr("HOLD1", I_ADD,  0, 0, 1, 1, 0, 1);
        do_instr("HOLD2", I_MRET, 0, 0, 1, 1, 1, 0);
        for (int i = 3; i <= 10; i++)
            do_instr($sformatf("HOLD%0d", i), I_ADD, 0, 1, 1, 1, 0, 0);

        @(negedge clk);
        #1;
        check_val("drain", 13'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/virgule_sequencer.md
# virgule_sequencer

Multi-cycle control FSM for the Virgule core. Each instruction is sequenced through fetch, decode, execute, optional memory access and writeback. The sequencer owns the memory-bus handshake and the register/PC write enables. It also accepts and retires interrupts. It sits between the instruction register/decoder output (`instruction_t`) and the datapath enables; it contains no datapath arithmetic.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr`  in  `instruction_t`  decoded instruction; only `is_load`, `is_store`, `is_mret`, `has_rd` are used.
- `bus_ready`  in  1  memory acknowledge for the current request.
- `irq`  in  1  external interrupt request, level, synchronous to `clk`.
- `bus_valid`  out  1  memory request active.
- `bus_write`  out  1  current request is a store.
- `is_fetch`, `is_decode`, `is_execute`, `is_load`, `is_store`, `is_writeback`  out  1 each  one-hot state indicators.
- `instr_we`  out  1  latch fetched word into instruction register.
- `pc_we`  out  1  update PC.
- `rd_we`  out  1  write register file.
- `irq_taken`  out  1  PC update targets trap vector and saves return PC.
- `in_handler`  out  1  interrupt handler active.

## Operation
- States: FETCH, DECODE, EXECUTE, LOAD, STORE, WRITEBACK. Encoding is free; the six `is_*` outputs are exactly one-hot.
- Transitions:
  - FETCH -> DECODE when `bus_ready`; otherwise FETCH.
  - DECODE -> EXECUTE unconditionally.
  - EXECUTE -> LOAD if `instr.is_load`; else STORE if `instr.is_store`; else WRITEBACK.
  - LOAD -> WRITEBACK and STORE -> WRITEBACK when `bus_ready`; otherwise hold.
  - WRITEBACK -> FETCH unconditionally.
- `bus_valid` = (FETCH or LOAD or STORE) and not `reset`.
- `bus_write` = STORE.
- `instr_we` = FETCH and `bus_ready`.
- `pc_we` = WRITEBACK.
- `rd_we` = WRITEBACK and `instr.has_rd`.
- Interrupt logic:
  - Register `irq_q` samples `irq`.
  - `irq_pending` is set on a rising edge (`irq` and not `irq_q`).
  - `irq_taken` = WRITEBACK and `irq_pending` and not `in_handler`. Both values are the registered ones, before any update this cycle.
  - When `irq_taken`: clear `irq_pending`, set `in_handler`.
  - WRITEBACK with `instr.is_mret`: clear `in_handler`. That same cycle cannot take an interrupt, because `in_handler` is still 1.
  - Set beats clear: a new rising edge in the same cycle as `irq_taken` leaves `irq_pending`=1.
  - An interrupt retired in a cycle where `rd_we` is 1 still writes rd. The instruction completes, then control traps.

## Timing
- Reset (asynchronous, any state): state=FETCH, `irq_q`=0, `irq_pending`=0, `in_handler`=0.
  - While `reset` is high: `bus_valid`=0, `is_fetch`=1, all other `is_*`=0, `instr_we`=`pc_we`=`rd_we`=`irq_taken`=0, `bus_write`=0.
- First `bus_valid` appears in the cycle after reset deasserts. Reset mid-transaction abandons the bus request immediately.
- Cycles per instruction, with zero-wait memory (`bus_ready` high in the first request cycle):
  - ALU, branch, jump, LUI/AUIPC, system: 4 cycles.
  - Load or store: 5 cycles.
  - Each wait cycle adds 1.
- `bus_valid` stays high and the state holds until `bus_ready`. `bus_ready` outside FETCH/LOAD/STORE is ignored.
- `instr` must be stable from DECODE through WRITEBACK. The instruction register is written only on `instr_we`.
- Interrupt latency: an irq edge registered during instruction N is taken at WRITEBACK of N if the edge arrives at least one cycle before that WRITEBACK. Otherwise it is taken at WRITEBACK of N+1.
- All enable outputs are combinational from registered state plus `bus_ready`/`instr`. There is no combinational path from `irq` to any output.

## Test plan
- Reset then ADD (`has_rd`=1), `bus_ready` tied 1:
  - Required: states FETCH, DECODE, EXECUTE, WRITEBACK over cycles 1-4.
  - `instr_we`=1 in cycle 1.
  - `rd_we`=`pc_we`=1 in cycle 4.
  - Next FETCH in cycle 5.
- LW with `bus_ready` low for 3 cycles in LOAD:
  - Required: LOAD held 4 cycles with `bus_valid`=1 and `bus_write`=0, then WRITEBACK with `rd_we`=1.
  - Total 8 cycles.
- SW, then BEQ (`has_rd`=0):
  - Required: STORE cycle with `bus_write`=1.
  - `rd_we`=0 in both WRITEBACKs.
  - `pc_we`=1 in both WRITEBACKs.
- irq pulse of 1 cycle during DECODE of ADD:
  - Required: `irq_taken`=1 at that WRITEBACK, `in_handler`=1 afterwards.
  - A second irq pulse is not taken until after the WRITEBACK of an MRET.
  - The MRET WRITEBACK itself has `irq_taken`=0.
  - The pending irq is taken at the following instruction's WRITEBACK.
- Assert `reset` during STORE with `bus_ready`=0:
  - Required: `bus_valid` drops in the same cycle, state=FETCH, and `in_handler`/`irq_pending` are cleared.
- irq held high continuously across 10 instructions:
  - Required: exactly one `irq_taken` (edge-triggered).
